// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg
// Shared definitions for the LCD1602 write sequencer: Z80 I/O port
// addresses, the FIFO entry layout, the sequencer FSM states and the bit
// positions inside the CPU status byte.
package lcd1602_pkg;

    // Z80 I/O port addresses (A[2:0])
    localparam logic [2:0] PORT_CMD = 3'b100;  // command write / status read
    localparam logic [2:0] PORT_DAT = 3'b101;  // data write

    // Status byte layout: {full, empty, busy, ovf, tmo, 0, level[1:0]}
    localparam int STAT_FULL  = 7;
    localparam int STAT_EMPTY = 6;
    localparam int STAT_BUSY  = 5;
    localparam int STAT_OVF   = 4;
    localparam int STAT_TMO   = 3;

    // One queued LCD transfer: register select plus the byte
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_SETUP,
        ST_W_E,
        ST_W_HOLD,
        ST_P_SETUP,
        ST_P_E,
        ST_P_HOLD,
        ST_P_GAP
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd1602_fifo.sv
// lcd1602_fifo
// Synchronous FIFO of {rs, data} entries feeding the LCD sequencer.
// A push while full is rejected unless a pop happens in the same cycle,
// in which case both are honoured. Output data is first-word-fall-through.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data write request and entry
//   pop             read request (ignored when empty)
//   pop_data        entry at the head of the FIFO
//   full, empty     occupancy flags
//   level           number of stored entries (0..FIFO_DEPTH)
module lcd1602_fifo
    import lcd1602_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  entry_t                        push_data,
    input  logic                          pop,
    output entry_t                        pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // When full, the slot being written is the one being read out this cycle
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lcd1602_sequencer.sv
// lcd1602_sequencer
// Autonomous HD44780/LCD1602 write sequencer on the Z80 I/O bus. The CPU
// writes command (port 4) and data (port 5) bytes which queue in a FIFO;
// the FSM writes each byte with proper E timing and then polls the busy
// flag (DB7) until the LCD is ready or the poll budget runs out.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   iorq_n, wr_n, rd_n, adr  Z80 control/address (asynchronous to clk)
//   cpu_d_in                 Z80 write data
//   cpu_d_out, cpu_d_oe      status byte and its bus drive enable
//   lcd_e, lcd_rs, lcd_rw    LCD control lines
//   lcd_d_out, lcd_d_oe      LCD data bus drive value and enable
//   lcd_d_in                 LCD data bus sampled value (busy flag on bit 7)
module lcd1602_sequencer
    import lcd1602_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int T_AS       = 2,
    parameter int T_EPW      = 12,
    parameter int T_AH       = 2,
    parameter int T_GAP      = 4,
    parameter int POLL_MAX   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iorq_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic [2:0] adr,
    input  logic [7:0] cpu_d_in,
    output logic [7:0] cpu_d_out,
    output logic       cpu_d_oe,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_d_out,
    output logic       lcd_d_oe,
    input  logic [7:0] lcd_d_in
);

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(max4(T_AS, T_EPW, T_AH, T_GAP) + 1);
    localparam int PC_W  = $clog2(POLL_MAX + 1);

    // Bus strobe synchronisers: [0],[1] are the two sync flops, [2] is
    // the delayed copy used for edge detection.
    logic [2:0]    wr_sync;
    logic [2:0]    rd_sync;
    logic          wr_fall;
    logic          rd_fall;
    logic          rd_rise;
    logic          rd_is_status;
    logic          status_clear;

    logic          push;
    entry_t        push_data;
    logic          pop;
    entry_t        pop_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;

    state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  poll_cnt;
    logic          bf;
    logic          ovf;
    logic          tmo;
    logic          busy;
    logic [1:0]    lvl_sat;
    logic [7:0]    status;
    logic          unused_bits;

    assign unused_bits = ^lcd_d_in[6:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sync      <= '1;
            rd_sync      <= '1;
            rd_is_status <= 1'b0;
        end else begin
            wr_sync <= {wr_sync[1:0], iorq_n | wr_n};
            rd_sync <= {rd_sync[1:0], iorq_n | rd_n};
            // Remember whether this read cycle targeted the status port so
            // the clear does not depend on the address after RD goes away.
            if (rd_fall) rd_is_status <= (adr == PORT_CMD);
        end
    end

    assign wr_fall      = wr_sync[2] & ~wr_sync[1];
    assign rd_fall      = rd_sync[2] & ~rd_sync[1];
    assign rd_rise      = ~rd_sync[2] & rd_sync[1];
    assign status_clear = rd_rise & rd_is_status;

    assign push           = wr_fall && ((adr == PORT_CMD) || (adr == PORT_DAT));
    assign push_data.rs   = (adr == PORT_DAT);
    assign push_data.data = cpu_d_in;
    assign pop            = (state == ST_IDLE) && !empty;

    lcd1602_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Sticky overflow; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else begin
            if (status_clear) ovf <= 1'b0;
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

    // Status port
    assign busy    = (state != ST_IDLE);
    assign lvl_sat = (level > LW'(3)) ? 2'b11 : level[1:0];

    always_comb begin
        status             = 8'h00;
        status[STAT_FULL]  = full;
        status[STAT_EMPTY] = empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = ovf;
        status[STAT_TMO]   = tmo;
        status[1:0]        = lvl_sat;
    end

    assign cpu_d_oe  = ~iorq_n & ~rd_n & (adr == PORT_CMD);
    assign cpu_d_out = cpu_d_oe ? status : 8'h00;

    // Sequencer: every phase loads cnt with its length minus one and
    // advances when it reaches zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            poll_cnt  <= '0;
            bf        <= 1'b0;
            tmo       <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_d_oe  <= 1'b0;
            lcd_d_out <= 8'h00;
        end else begin
            if (status_clear) tmo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        lcd_rs    <= pop_data.rs;
                        lcd_d_out <= pop_data.data;
                        lcd_rw    <= 1'b0;
                        lcd_d_oe  <= 1'b1;
                        cnt       <= CNT_W'(T_AS - 1);
                        state     <= ST_W_SETUP;
                    end
                end
                ST_W_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= CNT_W'(T_EPW - 1);
                        state <= ST_W_E;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_W_E: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        cnt   <= CNT_W'(T_AH - 1);
                        state <= ST_W_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_W_HOLD: begin
                    if (cnt == '0) begin
                        // Release the bus in the same cycle RW turns to read
                        lcd_d_oe <= 1'b0;
                        lcd_rs   <= 1'b0;
                        lcd_rw   <= 1'b1;
                        poll_cnt <= '0;
                        cnt      <= CNT_W'(T_AS - 1);
                        state    <= ST_P_SETUP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_P_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= CNT_W'(T_EPW - 1);
                        state <= ST_P_E;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_P_E: begin
                    if (cnt == '0) begin
                        bf    <= lcd_d_in[7];
                        lcd_e <= 1'b0;
                        cnt   <= CNT_W'(T_AH - 1);
                        state <= ST_P_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_P_HOLD: begin
                    if (cnt == '0) begin
                        if (!bf) begin
                            lcd_rw <= 1'b0;
                            state  <= ST_IDLE;
                        end else if (poll_cnt == PC_W'(POLL_MAX - 1)) begin
                            // This was poll number POLL_MAX: give up
                            tmo    <= 1'b1;
                            lcd_rw <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            cnt      <= CNT_W'(T_GAP - 1);
                            state    <= ST_P_GAP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_P_GAP: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_W'(T_AS - 1);
                        state <= ST_P_SETUP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    lcd_e    <= 1'b0;
                    lcd_rw   <= 1'b0;
                    lcd_d_oe <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
